// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states and frame geometry.
package loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, instruction-memory and core-control signals of the program loader.
// The master side is the host feeding bytes; the slave side is the loader itself.
interface program_loader_if #(
  parameter int ADDR_W = 8
);

  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imu_wen;
  logic [ADDR_W-1:0] imu_addr;
  logic [31:0]       imu_data;
  logic              cpu_clr;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, imu_wen, imu_addr, imu_data, cpu_clr, done, error, words_loaded
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, imu_wen, imu_addr, imu_data, cpu_clr, done, error, words_loaded
  );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs big-endian bytes into 32-bit words. o_word is the word completed by the
// byte currently being shifted, and o_word_full flags that this shift finishes a word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [1:0]  r_cnt;
  logic [23:0] r_word;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= 2'd0;
      r_word <= 24'd0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
      r_word <= 24'd0;
    end else if (i_shift) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= {r_word[15:0], i_byte};
    end
  end

  assign o_word      = {r_word, i_byte};
  assign o_word_full = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image byte by byte,
// writes it to instruction memory and releases the core only after verification.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           clr,
  program_loader_if.slave bus
);

  localparam logic [LEN_W:0]    LP_DEPTH = (LEN_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [7:0]        r_csum;
  logic              r_rx_ready;
  logic              r_imu_wen;
  logic [ADDR_W-1:0] r_imu_addr;
  logic [31:0]       r_imu_data;
  logic              r_cpu_clr;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_words_loaded;

  logic              w_fire;
  logic              w_arm;
  logic              w_asm_shift;
  logic [31:0]       w_word;
  logic              w_word_full;
  logic [LEN_W-1:0]  w_len;
  logic [ADDR_W:0]   w_loaded_next;

  assign w_fire        = bus.rx_valid && r_rx_ready;
  assign w_arm         = bus.start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_asm_shift   = w_fire && (r_state == DATA);
  assign w_len         = {r_len[LEN_W-1:8], bus.rx_data};
  assign w_loaded_next = r_words_loaded + 1'b1;

  byte_assembler u_asm (
    .clk         (clk),
    .clr         (clr),
    .i_clear     (w_arm),
    .i_shift     (w_asm_shift),
    .i_byte      (bus.rx_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // rx_ready and the other outputs are loaded together with the next state so they decode it without lag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_csum         <= 8'd0;
      r_rx_ready     <= 1'b0;
      r_imu_wen      <= 1'b0;
      r_imu_addr     <= '0;
      r_imu_data     <= 32'd0;
      r_cpu_clr      <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_imu_wen <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            r_state        <= LEN_HI;
            r_rx_ready     <= 1'b1;
            r_cpu_clr      <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_csum         <= 8'd0;
          end
        end
        LEN_HI: begin
          if (w_fire) begin
            r_len[LEN_W-1:8] <= bus.rx_data;
            r_state          <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (w_fire) begin
            r_len <= w_len;
            if (w_len == '0) begin
              r_state <= CSUM;
            end else if ({1'b0, w_len} > LP_DEPTH) begin
              r_state    <= ERR;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_fire) begin
            r_csum <= r_csum ^ bus.rx_data;
            if (w_word_full) begin
              r_state    <= WRITE;
              r_rx_ready <= 1'b0;
              r_imu_wen  <= 1'b1;
              r_imu_addr <= LP_BASE + r_words_loaded[ADDR_W-1:0];
              r_imu_data <= w_word;
            end
          end
        end
        WRITE: begin
          r_words_loaded <= w_loaded_next;
          r_rx_ready     <= 1'b1;
          if (LEN_W'(w_loaded_next) == r_len) begin
            r_state <= CSUM;
          end else begin
            r_state <= DATA;
          end
        end
        CSUM: begin
          if (w_fire) begin
            r_rx_ready <= 1'b0;
            if (bus.rx_data == r_csum) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_cpu_clr <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready     = r_rx_ready;
  assign bus.imu_wen      = r_imu_wen;
  assign bus.imu_addr     = r_imu_addr;
  assign bus.imu_data     = r_imu_data;
  assign bus.cpu_clr      = r_cpu_clr;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, bad checksum, oversize, empty,
// flow-control and mid-load reset scenarios with hand-computed expectations.
module tb_program_loader;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (256),
    .BASE_ADDR (0)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]        frame_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // Write monitor: records every write cycle and checks the loader is not accepting bytes then.
  always @(negedge clk) begin
    if (bus.imu_wen === 1'b1) begin
      wr_addr_q.push_back(bus.imu_addr);
      wr_data_q.push_back(bus.imu_data);
      checks++;
      if (bus.rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL rx_ready_in_write: rx_ready=%b required 0 (addr %0d)", bus.rx_ready, bus.imu_addr);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    @(negedge clk);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1 && n < 4) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL handshake_timeout: byte %02h rx_ready=%b required 1", b, bus.rx_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame_q[i]) send_byte(frame_q[i], gaps);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic load_nominal(input logic [7:0] csum);
    frame_q = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, csum};
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(bus.done === 1'b1 || bus.error === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_end_timeout: done=%b error=%b required one of them 1", name, bus.done, bus.error);
    end
  endtask

  task automatic check_nominal_writes(input string name);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required 2", name, wr_addr_q.size());
    end else begin
      checks += 4;
      if (wr_addr_q[0] !== 8'd0) begin
        errors++; $display("FAIL %s_addr0: got %0d required 0", name, wr_addr_q[0]);
      end
      if (wr_data_q[0] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL %s_data0: got %08h required DEADBEEF", name, wr_data_q[0]);
      end
      if (wr_addr_q[1] !== 8'd1) begin
        errors++; $display("FAIL %s_addr1: got %0d required 1", name, wr_addr_q[1]);
      end
      if (wr_data_q[1] !== 32'h01234567) begin
        errors++; $display("FAIL %s_data1: got %08h required 01234567", name, wr_data_q[1]);
      end
    end
  endtask

  task automatic check_done(input string name, input logic [ADDR_W:0] words);
    checks += 4;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL %s_done: got %b required 1", name, bus.done);
    end
    if (bus.error !== 1'b0) begin
      errors++; $display("FAIL %s_error: got %b required 0", name, bus.error);
    end
    if (bus.cpu_clr !== 1'b0) begin
      errors++; $display("FAIL %s_cpu_clr: got %b required 0", name, bus.cpu_clr);
    end
    if (bus.words_loaded !== words) begin
      errors++; $display("FAIL %s_words_loaded: got %0d required %0d", name, bus.words_loaded, words);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks += 8;
    if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL %s_rx_ready: got %b required 0", name, bus.rx_ready); end
    if (bus.imu_wen !== 1'b0) begin errors++; $display("FAIL %s_imu_wen: got %b required 0", name, bus.imu_wen); end
    if (bus.imu_addr !== 8'd0) begin errors++; $display("FAIL %s_imu_addr: got %0d required 0", name, bus.imu_addr); end
    if (bus.imu_data !== 32'd0) begin errors++; $display("FAIL %s_imu_data: got %08h required 0", name, bus.imu_data); end
    if (bus.cpu_clr !== 1'b1) begin errors++; $display("FAIL %s_cpu_clr: got %b required 1", name, bus.cpu_clr); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b required 0", name, bus.done); end
    if (bus.error !== 1'b0) begin errors++; $display("FAIL %s_error: got %b required 0", name, bus.error); end
    if (bus.words_loaded !== 9'd0) begin errors++; $display("FAIL %s_words_loaded: got %0d required 0", name, bus.words_loaded); end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    clr = 1'b0;
    @(negedge clk);
    $display("test_reset: reset values checked");
  endtask

  task automatic test_nominal();
    clear_writes();
    pulse_start();
    checks += 2;
    if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL nominal_armed_rx_ready: got %b required 1", bus.rx_ready); end
    if (bus.cpu_clr !== 1'b1) begin errors++; $display("FAIL nominal_armed_cpu_clr: got %b required 1", bus.cpu_clr); end
    load_nominal(8'h22);
    send_frame(1'b0);
    wait_end("nominal");
    check_nominal_writes("nominal");
    check_done("nominal", 9'd2);
    $display("test_nominal: writes=%0d done=%b", wr_addr_q.size(), bus.done);
  endtask

  task automatic test_bad_checksum();
    clear_writes();
    pulse_start();
    checks++;
    if (bus.cpu_clr !== 1'b1) begin errors++; $display("FAIL badcsum_rearm_cpu_clr: got %b required 1", bus.cpu_clr); end
    load_nominal(8'h23);
    send_frame(1'b0);
    wait_end("badcsum");
    check_nominal_writes("badcsum");
    checks += 3;
    if (bus.error !== 1'b1) begin errors++; $display("FAIL badcsum_error: got %b required 1", bus.error); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL badcsum_done: got %b required 0", bus.done); end
    if (bus.cpu_clr !== 1'b1) begin errors++; $display("FAIL badcsum_cpu_clr: got %b required 1", bus.cpu_clr); end
    $display("test_bad_checksum: error=%b", bus.error);
    clear_writes();
    pulse_start();
    checks++;
    if (bus.error !== 1'b0) begin errors++; $display("FAIL badcsum_restart_error: got %b required 0", bus.error); end
    load_nominal(8'h22);
    send_frame(1'b0);
    wait_end("recover");
    check_nominal_writes("recover");
    check_done("recover", 9'd2);
    $display("test_bad_checksum: recovery done=%b", bus.done);
  endtask

  task automatic test_oversize();
    clear_writes();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    checks += 4;
    if (bus.error !== 1'b1) begin errors++; $display("FAIL oversize_error: got %b required 1", bus.error); end
    if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL oversize_rx_ready: got %b required 0", bus.rx_ready); end
    if (bus.cpu_clr !== 1'b1) begin errors++; $display("FAIL oversize_cpu_clr: got %b required 1", bus.cpu_clr); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL oversize_done: got %b required 0", bus.done); end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL oversize_writes: got %0d required 0", wr_addr_q.size()); end
    $display("test_oversize: error=%b writes=%0d", bus.error, wr_addr_q.size());
  endtask

  task automatic test_empty();
    clear_writes();
    pulse_start();
    frame_q = {8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    wait_end("empty");
    check_done("empty", 9'd0);
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL empty_writes: got %0d required 0", wr_addr_q.size()); end
    $display("test_empty: done=%b writes=%0d", bus.done, wr_addr_q.size());
  endtask

  task automatic test_flow_control();
    clear_writes();
    pulse_start();
    load_nominal(8'h22);
    send_frame(1'b1);
    wait_end("flow");
    check_nominal_writes("flow");
    check_done("flow", 9'd2);
    $display("test_flow_control: writes=%0d done=%b", wr_addr_q.size(), bus.done);
  endtask

  task automatic test_reset_mid_load();
    clear_writes();
    pulse_start();
    frame_q = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    #3;
    clr = 1'b1;
    #1;
    check_reset_values("midreset");
    bus.rx_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    $display("test_reset_mid_load: outputs reset between edges");
    clear_writes();
    pulse_start();
    load_nominal(8'h22);
    send_frame(1'b0);
    wait_end("midreset_reload");
    check_nominal_writes("midreset_reload");
    check_done("midreset_reload", 9'd2);
    $display("test_reset_mid_load: reload done=%b", bus.done);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    clr          = 1'b1;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_flow_control();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
